// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: word-address PC, one in-flight read, 2-entry {pc,instr} queue to decode.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        fetch_en,
  input  logic        IsBranchTaken,
  input  logic [31:0] BranchPC,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t      state;
  logic [31:0] pc_next;
  logic [31:0] inflight_pc;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        rd_ptr;
  logic [1:0]  count;
  logic        inflight;

  logic        in_halt;
  logic        redirect;
  logic        pop;
  logic        capture;
  logic        issue;
  logic        wr_slot;
  logic [2:0]  occupancy;

`ifdef FETCH_HALT_DETECT_EN
  logic        halt_hit;
  assign in_halt  = (state == HALT);
  assign halt_hit = capture && (imem_data[31:27] == 5'b11111);
`else
  assign in_halt  = 1'b0;
`endif

  assign redirect  = IsBranchTaken && !in_halt;
  assign if_valid  = (count != 2'd0);
  assign pop       = if_valid && if_ready;
  // A response is only ever owned by the cycle right after its strobe; redirect or halt drops it.
  assign capture   = inflight && !redirect && !in_halt;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && fetch_en && !redirect && (occupancy < 3'd2);
  // Tail slot after this cycle's pop; with count==2 and a pop it reuses the head slot.
  assign wr_slot   = rd_ptr ^ count[0];

  assign imem_rd   = issue;
  assign imem_addr = pc_next;
  assign if_instr  = if_valid ? q_instr[rd_ptr] : '0;
  assign if_pc     = if_valid ? q_pc[rd_ptr]    : '0;
  assign halted    = in_halt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      pc_next     <= '0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      inflight    <= 1'b0;
      q_pc[0]     <= '0;
      q_pc[1]     <= '0;
      q_instr[0]  <= '0;
      q_instr[1]  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_next;
      end

      if (redirect) begin
        count   <= '0;
        rd_ptr  <= 1'b0;
        pc_next <= BranchPC;
      end else begin
        if (capture) begin
          q_pc[wr_slot]    <= inflight_pc;
          q_instr[wr_slot] <= imem_data;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, capture} - {1'b0, pop};
        if (issue) begin
          pc_next <= pc_next + 32'd1;
        end
      end

      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= state;
      endcase
`ifdef FETCH_HALT_DETECT_EN
      if (halt_hit) begin
        state <= HALT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected delivery stream per fetch segment, randomized handshake and redirects.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        IsBranchTaken = 1'b0;
  logic [31:0] BranchPC = '0;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;

  fetch_sequencer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .fetch_en      (fetch_en),
    .IsBranchTaken (IsBranchTaken),
    .BranchPC      (BranchPC),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  int          reads = 0;
  ent_t        exp_q[$];
  logic [31:0] exp_issue = '0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_issue = '0;
  bit          halt_img = 1'b0;
  bit          model_halted = 1'b0;

  // Memory image: fixed words at 0..2, optional halt opcode at 3, hashed words elsewhere (never 5'b11111 on top).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0000_0000;
    if (a == 32'd1) return 32'h4c40_0002;
    if (a == 32'd2) return 32'h4c80_0006;
    if (a == 32'd3 && halt_img) return 32'hF800_0000;
    return (a * 32'h9E37_79B1 + 32'h0BAD_F00D) & 32'h7FFF_FFFF;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset)       imem_data <= '0;
    else if (imem_rd) imem_data <= mem_word(imem_addr);
    else              imem_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_bit({tag, "_imem_rd"}, imem_rd, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check_bit({tag, "_if_valid"}, if_valid, 1'b0);
    check({tag, "_if_instr"}, if_instr, 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check_bit({tag, "_halted"}, halted, 1'b0);
  endtask

  // New fetch segment: decode must see target, target+1, ... in order, fetches start at target.
  task automatic start_stream(input logic [31:0] target);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      a = target + 32'(i);
      exp_q.push_back('{pc: a, instr: mem_word(a)});
    end
    exp_issue = target;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_rd(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (imem_rd) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: no imem_rd within %0d cycles", name, budget);
    end
  endtask

  // Fetch-side monitor: strobes must walk the expected address sequence, never in a redirect cycle.
  always @(negedge Clk) begin
    if (Reset) begin
      if (IsBranchTaken && !model_halted) begin
        check_bit("rd_in_redirect", imem_rd, 1'b0);
      end else if (imem_rd) begin
        check("issue_addr", imem_addr, exp_issue);
        exp_issue  = exp_issue + 32'd1;
        last_issue = imem_addr;
        reads++;
      end else begin
        check("idle_addr", imem_addr, exp_issue);
      end
    end
  end

  // Decode-side monitor: every accepted head is popped against the scoreboard.
  always @(negedge Clk) begin
    if (Reset && if_valid && if_ready && !(IsBranchTaken && !model_halted)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL deliver_unexpected: got pc %h expected none", if_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("deliver_pc", if_pc, e.pc);
        check("deliver_instr", if_instr, e.instr);
      end
      last_pc = if_pc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] k;
    logic [31:0] target;
    int          r0;
    int          seg;
    bit          found;

    #12 check_zero("reset");
    start_stream(32'd0);
    fetch_en = 1'b1;
    if_ready = 1'b1;
    tick();
    Reset = 1'b1;

    // Back-to-back fetch from reset.
    wait_rd(20, "r030_first_rd");
    check("r030_addr0", imem_addr, 32'd0);
    @(negedge Clk);
    check_bit("r030_rd1", imem_rd, 1'b1);
    check("r030_addr1", imem_addr, 32'd1);
    check_bit("r030_novalid", if_valid, 1'b0);
    @(negedge Clk);
    check_bit("r030_rd2", imem_rd, 1'b1);
    check("r030_addr2", imem_addr, 32'd2);
    check_bit("r030_valid0", if_valid, 1'b1);
    check("r030_pc0", if_pc, 32'd0);
    @(negedge Clk);
    check("r030_pc1", if_pc, 32'd1);
    check("r030_instr1", if_instr, 32'h4c40_0002);
    @(negedge Clk);
    check("r030_pc2", if_pc, 32'd2);
    check("r030_instr2", if_instr, 32'h4c80_0006);

    // Back-pressure: restart at 0 with decode stalled.
    tick();
    IsBranchTaken = 1'b1;
    BranchPC = 32'd0;
    if_ready = 1'b0;
    start_stream(32'd0);
    r0 = reads;
    tick();
    IsBranchTaken = 1'b0;
    repeat (9) @(negedge Clk);
    check("r031_reads", 32'(reads - r0), 32'd2);
    check_bit("r031_valid", if_valid, 1'b1);
    check("r031_pc_hold", if_pc, 32'd0);
    tick();
    if_ready = 1'b1;

    // Redirect with address 5 in flight.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (imem_rd && imem_addr == 32'd5) begin
        found = 1'b1;
        break;
      end
    end
    check_bit("r032_saw_addr5", found, 1'b1);
    tick();
    IsBranchTaken = 1'b1;
    BranchPC = 32'h40;
    if_ready = 1'b0;
    start_stream(32'h40);
    @(negedge Clk);
    check_bit("r032_suppress", imem_rd, 1'b0);
    tick();
    IsBranchTaken = 1'b0;
    if_ready = 1'b1;
    @(negedge Clk);
    check_bit("r032_rd_target", imem_rd, 1'b1);
    check("r032_addr_target", imem_addr, 32'h40);
    @(negedge Clk);
    check_bit("r032_flushed", if_valid, 1'b0);
    @(negedge Clk);
    check_bit("r032_valid_target", if_valid, 1'b1);
    check("r032_pc_target", if_pc, 32'h40);

    // fetch_en drop with a read in flight.
    wait_rd(10, "r033_rd");
    k = imem_addr;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check_bit("r033_no_rd", imem_rd, 1'b0);
    end
    check("r033_inflight_delivered", last_pc, k);
    check_bit("r033_drained", if_valid, 1'b0);
    tick();
    fetch_en = 1'b1;
    wait_rd(10, "r033_resume");
    check("r033_resume_addr", imem_addr, k + 32'd1);

    // Halt opcode at address 3.
    tick();
    Reset = 1'b0;
    #1;
    halt_img = 1'b1;
    model_halted = 1'b0;
    start_stream(32'd0);
    tick();
    Reset = 1'b1;
    repeat (15) @(negedge Clk);
`ifdef FETCH_HALT_DETECT_EN
    check_bit("r034_halted", halted, 1'b1);
    check("r034_last_pc", last_pc, 32'd3);
    check("r034_last_issue", last_issue, 32'd4);
    check_bit("r034_empty", if_valid, 1'b0);
    model_halted = 1'b1;
    tick();
    IsBranchTaken = 1'b1;
    BranchPC = 32'h100;
    tick();
    IsBranchTaken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_bit("r034_no_rd", imem_rd, 1'b0);
      check_bit("r034_stay_halted", halted, 1'b1);
      check("r034_addr_kept", imem_addr, 32'd5);
    end
`else
    check_bit("r029_not_halted", halted, 1'b0);
    check_bit("r029_continues", last_pc > 32'd4, 1'b1);
`endif

    // Asynchronous reset with the queue full.
    tick();
    Reset = 1'b0;
    #1;
    halt_img = 1'b0;
    model_halted = 1'b0;
    start_stream(32'd0);
    tick();
    Reset = 1'b1;
    if_ready = 1'b0;
    repeat (8) @(negedge Clk);
    check_bit("r035_full_valid", if_valid, 1'b1);
    check("r035_full_pc", if_pc, 32'd0);
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1 check_zero("r035_async");
    tick();
    start_stream(32'd0);
    Reset = 1'b1;
    if_ready = 1'b1;
    wait_rd(10, "r035_restart");
    check("r035_restart_addr", imem_addr, 32'd0);

    // Randomized traffic, including redirects that wrap the address space.
    seg = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      IsBranchTaken = 1'b0;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) fetch_en = ~fetch_en;
      if ($urandom_range(0, 19) == 0 || seg > 150) begin
        target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom);
        IsBranchTaken = 1'b1;
        BranchPC = target;
        if_ready = 1'b0;
        start_stream(target);
        seg = 0;
      end else begin
        seg++;
      end
    end
    tick();
    IsBranchTaken = 1'b0;
    fetch_en = 1'b0;
    if_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
